// File: rtl/imu_regs_pkg.sv
// rtl/imu_regs_pkg.sv - shared AXI response codes and control-register bit positions
package imu_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_HOLD   = 1;

endpackage

// File: rtl/imu_axil_regs.sv
// rtl/imu_axil_regs.sv - AXI4-Lite register block: RW control regs plus coherent IMU sample shadows
module imu_axil_regs
    import imu_regs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int N_RW   = 4,
    parameter int N_RO   = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [ADDR_W-1:0]      S_AXI_AWADDR,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [DATA_W-1:0]      S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]    S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ADDR_W-1:0]      S_AXI_ARADDR,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [DATA_W-1:0]      S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [N_RW*DATA_W-1:0] ctrl_o,
    input  logic [N_RO*DATA_W-1:0] sample_i,
    input  logic                   sample_valid_i,
    output logic                   irq_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LSB;

    logic [DATA_W-1:0] rw_q     [N_RW];
    logic [DATA_W-1:0] shadow_q [N_RO];

    logic              wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_flag_idx_q;
    logic              new_flag_q;

    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_hs, rd_hs, wr_is_rw;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_data_c;
    logic              capture, flag_clear;
    logic              unused_addr_lsbs;

    assign wr_idx   = S_AXI_AWADDR[ADDR_W-1:LSB];
    assign rd_idx   = S_AXI_ARADDR[ADDR_W-1:LSB];
    assign wr_hs    = wready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs    = arready_q & S_AXI_ARVALID;
    assign wr_is_rw = 32'(wr_idx) < 32'(N_RW);
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

    // Write channel: ready is a one-cycle pulse, blocked while a response is outstanding
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            for (int i = 0; i < N_RW; i++) rw_q[i] <= '0;
        end else begin
            wready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~wready_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_is_rw ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < N_RW; i++) begin
                    if (32'(wr_idx) == 32'(i)) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (S_AXI_WSTRB[b]) rw_q[i][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                        end
                    end
                end
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data_c   = '0;
        rd_in_range = 32'(rd_idx) < 32'(N_RW + N_RO);
        for (int i = 0; i < N_RW; i++) begin
            if (32'(rd_idx) == 32'(i)) rd_data_c = rw_q[i];
        end
        for (int j = 0; j < N_RO; j++) begin
            if (32'(rd_idx) == 32'(N_RW + j)) rd_data_c = shadow_q[j];
        end
    end

    // Read channel samples register contents before any same-edge write lands
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            rd_flag_idx_q <= 1'b0;
        end else begin
            arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
            if (rd_hs) begin
                rvalid_q      <= 1'b1;
                rdata_q       <= rd_data_c;
                rresp_q       <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                rd_flag_idx_q <= 32'(rd_idx) == 32'(N_RW);
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign capture    = sample_valid_i & ~rw_q[0][CTRL_HOLD];
    assign flag_clear = rvalid_q & S_AXI_RREADY & rd_flag_idx_q;

    // A capture in the same cycle as the clearing read wins, so no sample set goes unannounced
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            new_flag_q <= 1'b0;
            for (int j = 0; j < N_RO; j++) shadow_q[j] <= '0;
        end else begin
            if (capture) begin
                new_flag_q <= 1'b1;
                for (int j = 0; j < N_RO; j++) shadow_q[j] <= sample_i[j*DATA_W +: DATA_W];
            end else if (flag_clear) begin
                new_flag_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_RW; g++) begin : g_ctrl
        assign ctrl_o[g*DATA_W +: DATA_W] = rw_q[g];
    end

    assign irq_o         = new_flag_q & rw_q[0][CTRL_IRQ_EN];
    assign S_AXI_AWREADY = wready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_imu_axil_regs.sv
// tb/tb_imu_axil_regs.sv - directed table-driven bench for imu_axil_regs
module tb_imu_axil_regs;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int N_RW   = 4;
    localparam int N_RO   = 8;

    logic                   ACLK = 1'b0;
    logic                   ARESETN = 1'b0;
    logic [ADDR_W-1:0]      S_AXI_AWADDR = '0;
    logic                   S_AXI_AWVALID = 1'b0;
    logic                   S_AXI_AWREADY;
    logic [DATA_W-1:0]      S_AXI_WDATA = '0;
    logic [DATA_W/8-1:0]    S_AXI_WSTRB = '0;
    logic                   S_AXI_WVALID = 1'b0;
    logic                   S_AXI_WREADY;
    logic [1:0]             S_AXI_BRESP;
    logic                   S_AXI_BVALID;
    logic                   S_AXI_BREADY = 1'b0;
    logic [ADDR_W-1:0]      S_AXI_ARADDR = '0;
    logic                   S_AXI_ARVALID = 1'b0;
    logic                   S_AXI_ARREADY;
    logic [DATA_W-1:0]      S_AXI_RDATA;
    logic [1:0]             S_AXI_RRESP;
    logic                   S_AXI_RVALID;
    logic                   S_AXI_RREADY = 1'b0;
    logic [N_RW*DATA_W-1:0] ctrl_o;
    logic [N_RO*DATA_W-1:0] sample_i = '0;
    logic                   sample_valid_i = 1'b0;
    logic                   irq_o;

    imu_axil_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RW(N_RW), .N_RO(N_RO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ctrl_o(ctrl_o), .sample_i(sample_i), .sample_valid_i(sample_valid_i), .irq_o(irq_o)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_wr;
        int          idx;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic set_samples(input logic [31:0] base);
        for (int j = 0; j < N_RO; j++) sample_i[j*32 +: 32] = base + 32'(j);
    endtask

    task automatic pulse_samples(input logic [31:0] base);
        @(negedge ACLK);
        set_samples(base);
        sample_valid_i = 1'b1;
        @(posedge ACLK);
        #1 sample_valid_i = 1'b0;
    endtask

    task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        @(negedge ACLK);
        S_AXI_AWADDR  = 6'(idx * 4);
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_AWREADY) timeout("aw_ready");
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        @(negedge ACLK);
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_BVALID) timeout("b_valid");
        resp = S_AXI_BRESP;
        @(posedge ACLK);
        #1 S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input int idx, input bit pulse, input logic [31:0] pbase,
                            output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        S_AXI_ARADDR  = 6'(idx * 4);
        S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_ARREADY) timeout("ar_ready");
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        @(negedge ACLK);
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_RVALID) timeout("r_valid");
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        if (pulse) begin
            set_samples(pbase);
            sample_valid_i = 1'b1;
        end
        @(posedge ACLK);
        #1;
        S_AXI_RREADY   = 1'b0;
        sample_valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic [31:0] held;
        bit          ok;
        int          n;

        vecs.push_back('{1, 0, 32'h1, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1, 1, 32'h2, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1, 2, 32'h3, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1, 3, 32'h4, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 4'h0, 2'b00, 32'h1});
        vecs.push_back('{0, 1, 32'h0, 4'h0, 2'b00, 32'h2});
        vecs.push_back('{0, 2, 32'h0, 4'h0, 2'b00, 32'h3});
        vecs.push_back('{0, 3, 32'h0, 4'h0, 2'b00, 32'h4});
        vecs.push_back('{1, 1, 32'hAABBCCDD, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1, 1, 32'h11223344, 4'h5, 2'b00, 32'h0});
        vecs.push_back('{0, 1, 32'h0, 4'h0, 2'b00, 32'hAA22CC44});
        vecs.push_back('{0, 13, 32'h0, 4'h0, 2'b10, 32'h0});
        vecs.push_back('{1, 5, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0});
        vecs.push_back('{1, 15, 32'hCAFEF00D, 4'hF, 2'b10, 32'h0});
        vecs.push_back('{0, 5, 32'h0, 4'h0, 2'b00, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 4'h0, 2'b00, 32'h1});

        repeat (3) @(negedge ACLK);
        check("rst_awready", {127'b0, S_AXI_AWREADY}, 128'h0);
        check("rst_bvalid", {127'b0, S_AXI_BVALID}, 128'h0);
        check("rst_rvalid", {127'b0, S_AXI_RVALID}, 128'h0);
        check("rst_arready", {127'b0, S_AXI_ARREADY}, 128'h0);
        check("rst_rdata", {96'b0, S_AXI_RDATA}, 128'h0);
        check("rst_ctrl", ctrl_o, 128'h0);
        check("rst_irq", {127'b0, irq_o}, 128'h0);
        ARESETN = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].is_wr) begin
                axi_write(vecs[k].idx, vecs[k].data, vecs[k].strb, rsp);
                check($sformatf("vec%0d_bresp", k), {126'b0, rsp}, {126'b0, vecs[k].exp_resp});
            end else begin
                axi_read(vecs[k].idx, 1'b0, 32'h0, rd, rsp);
                check($sformatf("vec%0d_rdata", k), {96'b0, rd}, {96'b0, vecs[k].exp_data});
                check($sformatf("vec%0d_rresp", k), {126'b0, rsp}, {126'b0, vecs[k].exp_resp});
            end
        end
        check("ctrl_flat", ctrl_o, 128'h00000004_00000003_AA22CC44_00000001);

        // capture with irq enabled, then readout clears the flag
        pulse_samples(32'h100);
        @(negedge ACLK);
        check("irq_after_capture", {127'b0, irq_o}, 128'h1);
        for (int j = 0; j < N_RO; j++) begin
            axi_read(N_RW + j, 1'b0, 32'h0, rd, rsp);
            check($sformatf("shadow%0d", j), {94'b0, rsp, rd}, {94'b0, 2'b00, 32'h100 + 32'(j)});
            if (j == 0) begin
                @(negedge ACLK);
                check("irq_cleared", {127'b0, irq_o}, 128'h0);
            end
        end

        // hold freezes shadows and flag
        axi_write(0, 32'h3, 4'hF, rsp);
        pulse_samples(32'h200);
        @(negedge ACLK);
        check("hold_irq", {127'b0, irq_o}, 128'h0);
        axi_read(4, 1'b0, 32'h0, rd, rsp);
        check("hold_shadow4", {96'b0, rd}, 128'h100);
        axi_read(11, 1'b0, 32'h0, rd, rsp);
        check("hold_shadow11", {96'b0, rd}, 128'h107);

        // capture coinciding with the clearing read keeps the flag
        axi_write(0, 32'h1, 4'hF, rsp);
        pulse_samples(32'h300);
        axi_read(4, 1'b1, 32'h400, rd, rsp);
        check("race_rdata", {96'b0, rd}, 128'h300);
        @(negedge ACLK);
        check("race_irq_kept", {127'b0, irq_o}, 128'h1);
        axi_read(5, 1'b0, 32'h0, rd, rsp);
        check("race_shadow5", {96'b0, rd}, 128'h401);

        // B channel stall blocks a second write
        @(negedge ACLK);
        S_AXI_AWADDR = 6'd8; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_AWREADY) timeout("stall_aw");
        @(posedge ACLK);
        #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        S_AXI_AWADDR = 6'd12; S_AXI_WDATA = 32'h66;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge ACLK);
            if (!S_AXI_BVALID || S_AXI_AWREADY || S_AXI_BRESP !== 2'b00) ok = 1'b0;
        end
        check("b_stall_hold", {127'b0, ok}, 128'h1);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        #1 S_AXI_BREADY = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_AWREADY) timeout("stall_aw2");
        @(posedge ACLK);
        #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_BVALID) timeout("stall_b2");
        @(posedge ACLK);
        #1 S_AXI_BREADY = 1'b0;
        check("stall_ctrl23", ctrl_o[127:64], 64'h00000066_00000055);

        // R channel stall keeps data stable
        @(negedge ACLK);
        S_AXI_ARADDR = 6'd8; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_ARREADY) timeout("stall_ar");
        @(posedge ACLK);
        #1 S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        held = S_AXI_RDATA;
        ok = 1'b1;
        repeat (10) begin
            @(negedge ACLK);
            if (!S_AXI_RVALID || S_AXI_RDATA !== held) ok = 1'b0;
        end
        check("r_stall_hold", {127'b0, ok}, 128'h1);
        check("r_stall_data", {96'b0, held}, 128'h55);
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        #1 S_AXI_RREADY = 1'b0;

        // reset during an outstanding write response
        @(negedge ACLK);
        S_AXI_AWADDR = 6'd0; S_AXI_WDATA = 32'h7; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_AWREADY) timeout("rst_aw");
        @(posedge ACLK);
        #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        ARESETN = 1'b0;
        #1;
        check("midrst_bvalid", {127'b0, S_AXI_BVALID}, 128'h0);
        check("midrst_ctrl", ctrl_o, 128'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge ACLK);
            if (S_AXI_BVALID || S_AXI_RVALID || irq_o) ok = 1'b0;
        end
        check("postrst_quiet", {127'b0, ok}, 128'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
